// File: rtl/addr_mode_sequencer.sv
// 6502 effective-address sequencer: decodes the addressing mode of a new opcode,
// fetches operand bytes and zero-page pointers over req/ack, and reports the EA.
module addr_mode_sequencer #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16,
  parameter bit ZP_WRAP    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [REG_WIDTH-1:0]  opcode,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [REG_WIDTH-1:0]  x_in,
  input  logic [REG_WIDTH-1:0]  y_in,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  ea_valid,
  output logic [ADDR_WIDTH-1:0] ea,
  output logic [1:0]            operand_len,
  output logic                  page_cross,
  output logic                  is_imm,
  output logic                  illegal,
  output logic [2:0]            dbg_state
);

  // Memory port handshake: a read is pending while mem_req=1 with mem_addr held
  // stable; it completes on the rising edge where mem_ack=1, and mem_rdata is
  // captured on that same edge. mem_ack is ignored whenever mem_req=0.

  localparam int RW = REG_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] TWO_A = {{(AW-2){1'b0}}, 2'b10};
  localparam logic [RW-1:0] ONE_R = {{(RW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OP_LO  = 3'd1,
    S_OP_HI  = 3'd2,
    S_PTR_LO = 3'd3,
    S_PTR_HI = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    M_IMPL, M_IMM, M_ZPG, M_ZPG_X, M_ZPG_Y, M_REL,
    M_ABS, M_ABS_X, M_ABS_Y, M_X_IND, M_IND_Y
  } mode_t;

  state_t          state, next_state;
  mode_t           mode_q, dec_mode, cur_mode;
  logic [AW-1:0]   pc_q, ptr_q, ptr_calc;
  logic [RW-1:0]   b0_q, lo_q, idx;
  logic            idle_like, accept, is_ill_op;
  logic [AW-1:0]   ea_calc, word_base, rel_base;
  logic [RW:0]     low_sum;
  logic            pc_calc;

  function automatic logic [AW-1:0] zext(input logic [RW-1:0] v);
    return {{(AW-RW){1'b0}}, v};
  endfunction

  function automatic logic [AW-1:0] sext(input logic [RW-1:0] v);
    return {{(AW-RW){v[RW-1]}}, v};
  endfunction

  // Zero-page sum: wraps inside page zero, or carries into bit RW when wrap is off.
  function automatic logic [AW-1:0] zp_add(input logic [RW-1:0] a, input logic [RW-1:0] b);
    logic [RW:0]   s;
    logic [AW-1:0] r;
    s = {1'b0, a} + {1'b0, b};
    r = '0;
    if (ZP_WRAP) r[RW-1:0] = s[RW-1:0];
    else         r[RW:0]   = s;
    return r;
  endfunction

  function automatic logic [AW-1:0] zp_inc(input logic [AW-1:0] p);
    logic [AW-1:0] r;
    r = '0;
    if (ZP_WRAP) r[RW-1:0] = p[RW-1:0] + ONE_R;
    else         r         = p + ONE_A;
    return r;
  endfunction

  function automatic mode_t decode_mode(input logic [7:0] op);
    logic [2:0] aaa, bbb;
    logic [1:0] cc;
    mode_t      m;
    aaa = op[7:5];
    bbb = op[4:2];
    cc  = op[1:0];
    m   = M_IMPL;
    if (cc == 2'b01) begin
      case (bbb)
        3'b000:  m = M_X_IND;
        3'b001:  m = M_ZPG;
        3'b010:  m = M_IMM;
        3'b011:  m = M_ABS;
        3'b100:  m = M_IND_Y;
        3'b101:  m = M_ZPG_X;
        3'b110:  m = M_ABS_Y;
        default: m = M_ABS_X;
      endcase
    end else begin
      case (bbb)
        3'b000:  m = M_IMM;
        3'b001:  m = M_ZPG;
        3'b011:  m = M_ABS;
        3'b100:  m = M_REL;
        3'b101:  m = (cc == 2'b10 && (aaa == 3'b100 || aaa == 3'b101)) ? M_ZPG_Y : M_ZPG_X;
        3'b111:  m = (cc == 2'b10 && aaa == 3'b101) ? M_ABS_Y : M_ABS_X;
        default: m = M_IMPL;
      endcase
    end
    return m;
  endfunction

  function automatic logic [1:0] len_of(input mode_t m);
    case (m)
      M_ABS, M_ABS_X, M_ABS_Y: return 2'd2;
      M_IMPL:                  return 2'd0;
      default:                 return 2'd1;
    endcase
  endfunction

  assign dec_mode  = decode_mode(opcode[7:0]);
  assign is_ill_op = (opcode[1:0] == 2'b11);
  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign accept    = start && idle_like;
  assign cur_mode  = idle_like ? dec_mode : mode_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: begin
        next_state = S_IDLE;
        if (start && !is_ill_op) begin
          if (dec_mode == M_IMPL || dec_mode == M_IMM) next_state = S_DONE;
          else                                         next_state = S_OP_LO;
        end
      end
      S_OP_LO: begin
        if (mem_ack) begin
          case (mode_q)
            M_ABS, M_ABS_X, M_ABS_Y: next_state = S_OP_HI;
            M_X_IND, M_IND_Y:        next_state = S_PTR_LO;
            default:                 next_state = S_DONE;
          endcase
        end
      end
      S_OP_HI:  if (mem_ack) next_state = S_DONE;
      S_PTR_LO: if (mem_ack) next_state = S_PTR_HI;
      S_PTR_HI: if (mem_ack) next_state = S_DONE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = '0;
    busy      = 1'b0;
    ea_valid  = 1'b0;
    dbg_state = state;
    case (state)
      S_OP_LO: begin
        mem_req  = 1'b1;
        busy     = 1'b1;
        mem_addr = pc_q + ONE_A;
      end
      S_OP_HI: begin
        mem_req  = 1'b1;
        busy     = 1'b1;
        mem_addr = pc_q + TWO_A;
      end
      S_PTR_LO: begin
        mem_req  = 1'b1;
        busy     = 1'b1;
        mem_addr = ptr_q;
      end
      S_PTR_HI: begin
        mem_req  = 1'b1;
        busy     = 1'b1;
        mem_addr = zp_inc(ptr_q);
      end
      S_DONE:  ea_valid = 1'b1;
      default: ;
    endcase
  end

  // Effective-address arithmetic for whichever step is about to enter DONE.
  // The last fetched byte is still on mem_rdata, so it feeds the sum directly.
  always_comb begin
    ea_calc   = '0;
    pc_calc   = 1'b0;
    idx       = (cur_mode == M_ABS_Y || cur_mode == M_ZPG_Y || cur_mode == M_IND_Y) ? y_in : x_in;
    word_base = '0;
    word_base[2*RW-1:0] = (state == S_PTR_HI) ? {mem_rdata, lo_q} : {mem_rdata, b0_q};
    low_sum   = {1'b0, ((state == S_PTR_HI) ? lo_q : b0_q)} + {1'b0, idx};
    rel_base  = pc_q + TWO_A;
    case (cur_mode)
      M_IMM:            ea_calc = pc_in + ONE_A;
      M_ZPG:            ea_calc = zext(mem_rdata);
      M_ZPG_X, M_ZPG_Y: ea_calc = zp_add(mem_rdata, idx);
      M_REL: begin
        ea_calc = rel_base + sext(mem_rdata);
        pc_calc = (ea_calc[AW-1:RW] != rel_base[AW-1:RW]);
      end
      M_ABS, M_X_IND:   ea_calc = word_base;
      M_ABS_X, M_ABS_Y, M_IND_Y: begin
        ea_calc = word_base + zext(idx);
        pc_calc = low_sum[RW];
      end
      default: ;
    endcase
  end

  // X is folded into the pointer when the operand byte arrives.
  assign ptr_calc = (mode_q == M_X_IND) ? zp_add(mem_rdata, x_in) : zext(mem_rdata);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= M_IMPL;
      pc_q        <= '0;
      ptr_q       <= '0;
      b0_q        <= '0;
      lo_q        <= '0;
      ea          <= '0;
      operand_len <= 2'd0;
      page_cross  <= 1'b0;
      is_imm      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      illegal <= accept && is_ill_op;
      if (accept) begin
        mode_q <= dec_mode;
        pc_q   <= pc_in;
      end
      if (mem_req && mem_ack) begin
        case (state)
          S_OP_LO: begin
            b0_q  <= mem_rdata;
            ptr_q <= ptr_calc;
          end
          S_PTR_LO: lo_q <= mem_rdata;
          default: ;
        endcase
      end
      if (next_state == S_DONE) begin
        ea          <= ea_calc;
        page_cross  <= pc_calc;
        is_imm      <= (cur_mode == M_IMM);
        operand_len <= len_of(cur_mode);
      end
    end
  end

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// Bench for addr_mode_sequencer: directed 6502 cases, reset abort, then random
// opcodes checked against an arithmetic reference model and a memory responder.
module tb_addr_mode_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  opcode, x_in, y_in, mem_rdata;
  logic [15:0] pc_in, mem_addr, ea;
  logic        mem_req, mem_ack, busy, ea_valid, page_cross, is_imm, illegal;
  logic [1:0]  operand_len;
  logic [2:0]  dbg_state;

  addr_mode_sequencer #(.REG_WIDTH(8), .ADDR_WIDTH(16), .ZP_WRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .pc_in(pc_in),
    .x_in(x_in), .y_in(y_in), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .ea_valid(ea_valid),
    .ea(ea), .operand_len(operand_len), .page_cross(page_cross), .is_imm(is_imm),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  int          n_vec = 0;
  int          n_err = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          spurious_en = 1'b0;
  logic [15:0] first_addr;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int          exp_ea, exp_len, exp_pc, exp_imm, exp_ill, exp_lat;

  string mode_cc1  [8] = '{"XIND", "ZPG", "IMM", "ABS", "INDY", "ZPGX", "ABSY", "ABSX"};
  string mode_cc02 [8] = '{"IMM", "ZPG", "IMPL", "ABS", "REL", "ZPGX", "IMPL", "ABSX"};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after ack_delay wait cycles, logs every completed read.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt == 0) first_addr = mem_addr;
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        got_q.push_back(mem_addr);
        if (ack_delay > 0) check("addr_stable", mem_addr, first_addr);
        wait_cnt = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        wait_cnt++;
      end
    end else begin
      mem_ack   = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = 8'($urandom);
      wait_cnt  = 0;
    end
  end

  // Reference model: addressing mode by name, results by plain integer arithmetic.
  task automatic model(input int op, input int pc, input int x, input int y, input int delay);
    string m;
    int cc, bbb, aaa, b0, b1, p, lo, hi, base, off, idx;
    exp_q.delete();
    exp_ea = 0; exp_len = 1; exp_pc = 0; exp_imm = 0; exp_ill = 0;
    cc  = op % 4;
    bbb = (op / 4) % 8;
    aaa = op / 32;
    b0  = int'(mem[(pc + 1) % 65536]);
    b1  = int'(mem[(pc + 2) % 65536]);
    if (cc == 3) m = "ILL";
    else if (cc == 1) m = mode_cc1[bbb];
    else begin
      m = mode_cc02[bbb];
      if (cc == 2 && m == "ZPGX" && (aaa == 4 || aaa == 5)) m = "ZPGY";
      if (cc == 2 && m == "ABSX" && aaa == 5) m = "ABSY";
    end
    if (m != "ILL" && m != "IMPL" && m != "IMM") exp_q.push_back(16'((pc + 1) % 65536));
    if (m == "ILL") begin
      exp_ill = 1;
    end else if (m == "IMPL") begin
      exp_len = 0;
    end else if (m == "IMM") begin
      exp_ea  = (pc + 1) % 65536;
      exp_imm = 1;
    end else if (m == "ZPG") begin
      exp_ea = b0;
    end else if (m == "ZPGX" || m == "ZPGY") begin
      exp_ea = (b0 + ((m == "ZPGX") ? x : y)) % 256;
    end else if (m == "REL") begin
      base   = (pc + 2) % 65536;
      off    = (b0 >= 128) ? b0 - 256 : b0;
      exp_ea = (base + off + 65536) % 65536;
      exp_pc = int'(exp_ea / 256 != base / 256);
    end else if (m == "ABS") begin
      exp_q.push_back(16'((pc + 2) % 65536));
      exp_len = 2;
      exp_ea  = b1 * 256 + b0;
    end else if (m == "ABSX" || m == "ABSY") begin
      idx = (m == "ABSX") ? x : y;
      exp_q.push_back(16'((pc + 2) % 65536));
      exp_len = 2;
      exp_ea  = (b1 * 256 + b0 + idx) % 65536;
      exp_pc  = int'(b0 + idx > 255);
    end else if (m == "XIND") begin
      p = (b0 + x) % 256;
      exp_q.push_back(16'(p));
      exp_q.push_back(16'((p + 1) % 256));
      exp_ea = int'(mem[(p + 1) % 256]) * 256 + int'(mem[p]);
    end else begin
      exp_q.push_back(16'(b0));
      exp_q.push_back(16'((b0 + 1) % 256));
      lo = int'(mem[b0]);
      hi = int'(mem[(b0 + 1) % 256]);
      exp_ea = (hi * 256 + lo + y) % 65536;
      exp_pc = int'(lo + y > 255);
    end
    exp_lat = 1 + exp_q.size() * (1 + delay);
  endtask

  task automatic run_op(input logic [7:0] op, input logic [15:0] pc, input logic [7:0] x,
                        input logic [7:0] y, input int delay, input bit junk);
    int cyc;
    model(int'(op), int'(pc), int'(x), int'(y), delay);
    ack_delay = delay;
    got_q.delete();
    opcode = op; pc_in = pc; x_in = x; y_in = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!ea_valid && !illegal && cyc < 40) begin
      if (junk && busy) begin
        start  = 1'b1;
        opcode = 8'($urandom);
        pc_in  = 16'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check("latency", cyc, exp_lat);
    check("illegal", illegal, exp_ill);
    check("ea_valid", ea_valid, (exp_ill == 0) ? 1 : 0);
    if (exp_ill == 0) begin
      check("ea", ea, exp_ea);
      check("operand_len", operand_len, exp_len);
      check("page_cross", page_cross, exp_pc);
      check("is_imm", is_imm, exp_imm);
      check("busy_done", busy, 0);
    end
    check("n_fetch", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("fetch_addr", got_q[i], exp_q[i]);
    if (exp_ill != 0) begin
      @(negedge clk);
      check("illegal_pulse", illegal, 0);
      check("illegal_busy", busy, 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; start = 1'b0; opcode = '0; pc_in = '0; x_in = '0; y_in = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    idle(3);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_ea_valid", ea_valid, 0);
    check("rst_ea", ea, 0);
    check("rst_len", operand_len, 0);
    check("rst_page_cross", page_cross, 0);
    check("rst_is_imm", is_imm, 0);
    check("rst_illegal", illegal, 0);
    reset = 1'b0;
    idle(1);

    // LDA #imm
    run_op(8'hA9, 16'h0200, 8'h00, 8'h00, 0, 1'b0);
    check("tp1_ea", ea, 16'h0201);
    idle(1);
    // LDA zp,X with zero-page wrap
    mem[16'h0201] = 8'hF0;
    run_op(8'hB5, 16'h0200, 8'h20, 8'h00, 0, 1'b0);
    check("tp2_ea", ea, 16'h0010);
    // LDA abs,X crossing a page
    mem[16'h0202] = 8'h12;
    run_op(8'hBD, 16'h0200, 8'h20, 8'h00, 0, 1'b0);
    check("tp3_ea", ea, 16'h1310);
    check("tp3_pc", page_cross, 1);
    idle(2);
    // LDA (zp),Y with pointer wrapping from 0xFF to 0x00
    mem[16'h0201] = 8'hFF; mem[16'h00FF] = 8'hF0; mem[16'h0000] = 8'h12;
    run_op(8'hB1, 16'h0200, 8'h00, 8'h20, 0, 1'b0);
    check("tp4_ea", ea, 16'h1310);
    if (got_q.size() == 3) begin
      check("tp4_ptr_lo", got_q[1], 16'h00FF);
      check("tp4_ptr_hi", got_q[2], 16'h0000);
    end
    // LDX zp,Y then BNE forward across a page, back to back
    mem[16'h0201] = 8'h80;
    run_op(8'hB6, 16'h0200, 8'h01, 8'h05, 0, 1'b0);
    check("tp5_ea", ea, 16'h0085);
    mem[16'h02F1] = 8'h20;
    run_op(8'hD0, 16'h02F0, 8'h01, 8'h05, 0, 1'b0);
    check("tp5_rel_ea", ea, 16'h0312);
    check("tp5_rel_pc", page_cross, 1);
    idle(1);
    // LDA abs with two wait cycles per read
    mem[16'h0301] = 8'h34; mem[16'h0302] = 8'h12;
    run_op(8'hAD, 16'h0300, 8'h00, 8'h00, 2, 1'b0);
    check("tp6_ea", ea, 16'h1234);
    check("tp6_lat", exp_lat, 7);
    idle(1);

    // Reset while the high operand byte is outstanding
    ack_delay = 2;
    opcode = 8'hAD; pc_in = 16'h0400; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(3);
    check("rst_mid_req", mem_req, 1);
    check("rst_mid_addr", mem_addr, 16'h0402);
    reset = 1'b1;
    @(negedge clk);
    check("rst_abort_req", mem_req, 0);
    check("rst_abort_busy", busy, 0);
    check("rst_abort_ea_valid", ea_valid, 0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ea_valid) seen = 1'b1;
    end
    check("rst_no_ea_valid", seen, 0);

    // Illegal cc=11 opcode
    run_op(8'h03, 16'h0500, 8'h00, 8'h00, 0, 1'b0);

    // Random opcodes, operands, wait states and gaps
    spurious_en = 1'b1;
    for (int k = 0; k < 80; k++) begin
      run_op(8'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    spurious_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
